// File: rtl/key_debounce.sv
// key_debounce: per-key push-button debouncer with press/release pulses.
// Each active-low KEY bit is synchronised, then qualified by an independent
// IDLE/PRESS_WAIT/HELD/RELEASE_WAIT state machine that needs DEBOUNCE_CYC
// consecutive stable samples before accepting a level change.
// Optional feature macro: KEY_LONGPRESS_EN builds the hold counters and the
// KEY_LONG pulse (one pulse per accepted press once held LONG_CYC cycles).
// With the macro undefined KEY_LONG is tied to zero.

module key_debounce #(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int LONG_CYC     = 25_000_000
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_STATE,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_LONG
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    // Count value seen in the last waiting cycle; the entry cycle counts as
    // the first stable sample, so acceptance happens after DEBOUNCE_CYC samples.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 2);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Reject illegal parameter combinations at elaboration.
    if (DEBOUNCE_CYC < 2) begin : g_bad_db
        $error("key_debounce: DEBOUNCE_CYC must be >= 2");
    end
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
        $error("key_debounce: LONG_CYC must exceed DEBOUNCE_CYC");
    end

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    // Two-flop synchroniser; resets to released (1) so reset never looks like a press.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic            pressed;
        state_t          state;
        logic [DB_W-1:0] db_cnt;
        logic [DB_W-1:0] db_inc;
        logic            state_q;
        logic            press_q;
        logic            release_q;

        assign pressed = ~sync2[g];
        assign db_inc  = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);

`ifdef KEY_LONGPRESS_EN
        localparam int LG_W = $clog2(LONG_CYC + 1);
        localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYC);
        localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYC - 1);

        logic [LG_W-1:0] hold_cnt;
        logic            long_q;
`endif

        // Per-key FSM with registered pulses, level and (optionally) hold counter.
        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                state     <= IDLE;
                db_cnt    <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef KEY_LONGPRESS_EN
                hold_cnt  <= '0;
                long_q    <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef KEY_LONGPRESS_EN
                long_q    <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state  <= PRESS_WAIT;
                            db_cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state <= IDLE;
                        end else if (db_cnt >= DB_LAST) begin
                            state   <= HELD;
                            press_q <= 1'b1;
                            state_q <= 1'b1;
`ifdef KEY_LONGPRESS_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state  <= RELEASE_WAIT;
                            db_cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A re-press is a bounce: go back to HELD, keep the hold count.
                        if (pressed) begin
                            state <= HELD;
                        end else if (db_cnt >= DB_LAST) begin
                            state     <= IDLE;
                            release_q <= 1'b1;
                            state_q   <= 1'b0;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
`ifdef KEY_LONGPRESS_EN
                // Hold counter saturates at LONG_CYC, so the long pulse fires once per press.
                if ((state == HELD) || (state == RELEASE_WAIT)) begin
                    if (hold_cnt < LG_MAX) begin
                        hold_cnt <= hold_cnt + LG_W'(1);
                    end
                    if (hold_cnt == LG_LAST) begin
                        long_q <= 1'b1;
                    end
                end
`endif
            end
        end

        assign KEY_STATE[g]   = state_q;
        assign KEY_PRESS[g]   = press_q;
        assign KEY_RELEASE[g] = release_q;
`ifdef KEY_LONGPRESS_EN
        assign KEY_LONG[g]    = long_q;
`else
        assign KEY_LONG[g]    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus random key traffic, every cycle
// compared against a run-length reference model of the debouncer.
// Honours KEY_LONGPRESS_EN for the expected KEY_LONG behaviour.

module tb_key_debounce;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int LC = 32;

    logic          clk = 1'b0;
    logic          rstb;
    logic [NK-1:0] key;
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: accepted level, length of current opposite-level run,
    // cycles held since the press was accepted, and a 2-deep input delay.
    bit        m_lvl  [NK];
    int        m_run  [NK];
    int        m_hold [NK];
    logic [NK-1:0] m_s1, m_s2;
    logic [NK-1:0] e_st, e_pr, e_rl, e_lg;

    // Tallies of DUT observations for the directed scenarios.
    int cnt_pr [NK];
    int cnt_rl [NK];
    int cnt_lg [NK];
    bit seen_st[NK];
    bit seen_drop[NK];
    int all_press;
    int last_pr_cyc3;
    int last_lg_cyc3;

    key_debounce #(
        .NUM_KEYS    (NK),
        .DEBOUNCE_CYC(DB),
        .LONG_CYC    (LC)
    ) dut (
        .CLK        (clk),
        .RSTB       (rstb),
        .KEY        (key),
        .KEY_STATE  (st),
        .KEY_PRESS  (pr),
        .KEY_RELEASE(rl),
        .KEY_LONG   (lg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_lvl[k]  = 1'b0;
            m_run[k]  = 0;
            m_hold[k] = 0;
        end
        m_s1 = '1;
        m_s2 = '1;
        e_st = '0;
        e_pr = '0;
        e_rl = '0;
        e_lg = '0;
    endtask

    task automatic model_edge();
        if (!rstb) begin
            model_reset();
        end else begin
            e_pr = '0;
            e_rl = '0;
            e_lg = '0;
            for (int k = 0; k < NK; k++) begin
`ifdef KEY_LONGPRESS_EN
                if (m_lvl[k] && m_hold[k] < LC) begin
                    m_hold[k]++;
                    if (m_hold[k] == LC) e_lg[k] = 1'b1;
                end
`endif
                // Synchronised sample seen by the DUT in the cycle ending now.
                if ((m_s2[k] == 1'b0) != m_lvl[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DB) begin
                    m_lvl[k] = !m_lvl[k];
                    m_run[k] = 0;
                    if (m_lvl[k]) begin
                        e_pr[k]   = 1'b1;
                        m_hold[k] = 0;
                    end else begin
                        e_rl[k] = 1'b1;
                    end
                end
                e_st[k] = m_lvl[k];
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    endtask

    task automatic clear_tally();
        for (int k = 0; k < NK; k++) begin
            cnt_pr[k]    = 0;
            cnt_rl[k]    = 0;
            cnt_lg[k]    = 0;
            seen_st[k]   = 1'b0;
            seen_drop[k] = 1'b0;
        end
        all_press = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("key_state", st, e_st);
        check("key_press", pr, e_pr);
        check("key_release", rl, e_rl);
        check("key_long", lg, e_lg);
        check("press_and_release", pr & rl, '0);
        for (int k = 0; k < NK; k++) begin
            if (pr[k]) cnt_pr[k]++;
            if (rl[k]) cnt_rl[k]++;
            if (lg[k]) cnt_lg[k]++;
            if (st[k]) seen_st[k] = 1'b1;
            if (!st[k]) seen_drop[k] = 1'b1;
        end
        if (pr[3]) last_pr_cyc3 = cyc;
        if (lg[3]) last_lg_cyc3 = cyc;
        if (pr == 4'b1111) all_press++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rstb = 1'b1;
        key  = '1;
        last_pr_cyc3 = -1;
        last_lg_cyc3 = -1;
        model_reset();
        clear_tally();

        // Reset values, asynchronous, before any clock edge.
        #1 rstb = 1'b0;
        #1;
        check("reset_state", st, '0);
        check("reset_press", pr, '0);
        check("reset_release", rl, '0);
        check("reset_long", lg, '0);
        run(3);
        rstb = 1'b1;
        run(5);

        // Single clean press and release on key 0.
        clear_tally();
        key[0] = 1'b0;
        run(20);
        key[0] = 1'b1;
        run(20);
        check_int("k0_press_count", cnt_pr[0], 1);
        check_int("k0_release_count", cnt_rl[0], 1);
        check("k0_final_state", st, '0);

        // Bouncing key 1 never qualifies.
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            key[1] = ~key[1];
            run(3);
        end
        key[1] = 1'b1;
        run(15);
        check_int("k1_press_count", cnt_pr[1], 0);
        check_int("k1_state_seen", int'(seen_st[1]), 0);

        // Key 2 held with a short release glitch.
        clear_tally();
        key[2] = 1'b0;
        for (int i = 0; i < 40 && !st[2]; i++) step();
        check("k2_held_reached", st & 4'b0100, 4'b0100);
        run(20);
        clear_tally();
        key[2] = 1'b1;
        run(3);
        key[2] = 1'b0;
        run(20);
        check_int("k2_glitch_release", cnt_rl[2], 0);
        check_int("k2_glitch_drop", int'(seen_drop[2]), 0);
        key[2] = 1'b1;
        run(15);
        check_int("k2_final_release", cnt_rl[2], 1);

        // Long hold on key 3.
        clear_tally();
        key[3] = 1'b0;
        run(60);
        key[3] = 1'b1;
        run(15);
        check_int("k3_press_count", cnt_pr[3], 1);
`ifdef KEY_LONGPRESS_EN
        check_int("k3_long_count", cnt_lg[3], 1);
        check_int("k3_long_delay", last_lg_cyc3 - last_pr_cyc3, LC);
`else
        check_int("k3_long_count", cnt_lg[3], 0);
`endif

        // All keys pressed together, then reset mid-hold.
        clear_tally();
        key = '0;
        run(12);
        check_int("all_press_once", all_press, 1);
        run(5);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("midreset_state", st, '0);
        check("midreset_press", pr, '0);
        check("midreset_release", rl, '0);
        check("midreset_long", lg, '0);
        run(2);
        rstb = 1'b1;
        clear_tally();
        run(14);
        check_int("all_press_after_reset", all_press, 1);
        check("held_after_reset", st, 4'b1111);
        key = '1;
        run(15);

        // Random traffic: fast bouncing, then slower changes that qualify.
        clear_tally();
        for (int i = 0; i < 700; i++) begin
            for (int k = 0; k < NK; k++) begin
                if ((i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0))
                    key[k] = ~key[k];
            end
            step();
        end
        key = '1;
        run(20);
        for (int k = 0; k < NK; k++) begin
            check_int("rand_press_release_pairing", cnt_rl[k], cnt_pr[k]);
        end
        check("final_idle", st, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
